// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared state encodings, ALU operation codes and instruction constants for the multi-cycle control FSM.
// JUMP_LINK_EN enables jal/jr/jalr; without it those instructions decode as illegal.
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11
  } state_t;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_NOR = 5'b01000;
  localparam logic [4:0] ALU_XOR = 5'b01001;
  localparam logic [4:0] ALU_SLL = 5'b01010;
  localparam logic [4:0] ALU_SRL = 5'b10000;
  localparam logic [4:0] ALU_SRA = 5'b10001;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

`ifdef JUMP_LINK_EN
  localparam bit LINK_EN = 1'b1;
`else
  localparam bit LINK_EN = 1'b0;
`endif

  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA);
  endfunction

  function automatic logic is_reg_jump(input logic [5:0] fn);
    return LINK_EN && ((fn == F_JR) || (fn == F_JALR));
  endfunction

  function automatic logic r_legal(input logic [5:0] fn);
    case (fn)
      F_SLL, F_SRL, F_SRA, F_ADD, F_ADDU, F_SUB, F_SUBU,
      F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: return 1'b1;
      default:                                  return is_reg_jump(fn);
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_alu_ctrl_decode.sv
// Combinational ALU operation decode from FSM state and instruction fields; add outside EXEC/IEXEC/BR.
module alu_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [4:0] alu_conf_o,
  output logic       sign_o
);

  always_comb begin
    alu_conf_o = ALU_ADD;
    sign_o     = 1'b0;
    case (state_i)
      S_EXEC: begin
        case (funct_i)
          F_SUB, F_SUBU: alu_conf_o = ALU_SUB;
          F_AND:         alu_conf_o = ALU_AND;
          F_OR:          alu_conf_o = ALU_OR;
          F_XOR:         alu_conf_o = ALU_XOR;
          F_NOR:         alu_conf_o = ALU_NOR;
          F_SLL:         alu_conf_o = ALU_SLL;
          F_SRL:         alu_conf_o = ALU_SRL;
          F_SRA:         alu_conf_o = ALU_SRA;
          F_SLT: begin
            alu_conf_o = ALU_SLT;
            sign_o     = 1'b1;
          end
          F_SLTU:        alu_conf_o = ALU_SLT;
          default:       alu_conf_o = ALU_ADD;
        endcase
      end
      S_IEXEC: begin
        case (opcode_i)
          OP_ANDI:  alu_conf_o = ALU_AND;
          OP_SLTI: begin
            alu_conf_o = ALU_SLT;
            sign_o     = 1'b1;
          end
          OP_SLTIU: alu_conf_o = ALU_SLT;
          default:  alu_conf_o = ALU_ADD;
        endcase
      end
      S_BR:    alu_conf_o = ALU_SUB;
      default: alu_conf_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main multi-cycle CPU control FSM: sequences IF/ID/EX/MEM/WB and drives all datapath strobes.
// JUMP_LINK_EN (see package) adds jal/jr/jalr; otherwise they raise Illegal in ID.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [4:0] ALUConf,
  output logic       Sign,
  output logic       InstrDone,
  output logic       Illegal
);

  state_t     state_q, state_d;
  logic       id_illegal;
  logic [4:0] alu_conf_w;
  logic       sign_w;

  alu_ctrl_decode u_alu_dec (
    .state_i    (state_q),
    .opcode_i   (OpCode),
    .funct_i    (Funct),
    .alu_conf_o (alu_conf_w),
    .sign_o     (sign_w)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    id_illegal = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (OpCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            if (r_legal(Funct)) state_d = S_EXEC;
            else begin
              state_d    = S_IF;
              id_illegal = 1'b1;
            end
          end
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU, OP_LUI: state_d = S_IEXEC;
          OP_BEQ: state_d = S_BR;
          OP_J:   state_d = S_JMP;
          OP_JAL: begin
            state_d    = LINK_EN ? S_JMP : S_IF;
            id_illegal = !LINK_EN;
          end
          default: begin
            state_d    = S_IF;
            id_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = is_reg_jump(Funct) ? S_IF : S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_IF;
    endcase
  end

  always_comb begin
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 2'd0;
    MemtoReg  = 2'd0;
    ExtOp     = 1'b0;
    LuOp      = 1'b0;
    ALUSrcA   = 2'd0;
    ALUSrcB   = 2'd0;
    PCSource  = 2'd0;
    ALUConf   = alu_conf_w;
    Sign      = sign_w;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        PCWrite = 1'b1;
      end
      S_ID: begin
        ExtOp   = 1'b1;
        ALUSrcB = 2'd3;
        Illegal = id_illegal;
      end
      S_MEMADR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        ExtOp   = 1'b1;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 2'd1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        MemWrite  = 1'b1;
        IorD      = 1'b1;
        InstrDone = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = is_shift(Funct) ? 2'd2 : 2'd1;
        // jr/jalr complete here; jalr links PC (already PC+4) into rd
        if (is_reg_jump(Funct)) begin
          PCSource  = 2'd3;
          PCWrite   = 1'b1;
          InstrDone = 1'b1;
          if (Funct == F_JALR) begin
            RegWrite = 1'b1;
            RegDst   = 2'd1;
            MemtoReg = 2'd2;
          end
        end
      end
      S_RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 2'd1;
        InstrDone = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd2;
        ExtOp   = (OpCode != OP_ANDI);
        LuOp    = (OpCode == OP_LUI);
      end
      S_IWB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_BR: begin
        ALUSrcA   = 2'd1;
        PCSource  = 2'd1;
        PCWrite   = Zero;
        InstrDone = 1'b1;
      end
      S_JMP: begin
        PCSource  = 2'd2;
        PCWrite   = 1'b1;
        InstrDone = 1'b1;
        if (LINK_EN && (OpCode == OP_JAL)) begin
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
      end
      default: ;
    endcase
    // reset aborts whatever is in flight: no strobe may fire this cycle
    if (reset) begin
      PCWrite   = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      RegDst    = 2'd0;
      MemtoReg  = 2'd0;
      ExtOp     = 1'b0;
      LuOp      = 1'b0;
      ALUSrcA   = 2'd0;
      ALUSrcB   = 2'd0;
      PCSource  = 2'd0;
      ALUConf   = ALU_ADD;
      Sign      = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
    end
  end

endmodule
